sobel_window_feeder: RTL
========================

// Module: sobel_window_feeder
// PURPOSE
//  Upstream stage of the Sobel edge pipeline. Takes a raster pixel stream (valid/ready).
//  Keeps the last three image rows in a rotating line store.
//  Forms 3x7 pixel windows, stride 5 columns, and presents each one to the Sobel core on a
//  flat bus, together with the error setting.
//  Handshake with the core: a 1-cycle start pulse, then wait for its done pulse before the
//  next window.
// PARAMETERS
//  IMG_WIDTH   32   pixels per row; (IMG_WIDTH-2)%5==0 required (elaboration $error otherwise)
//  IMG_HEIGHT  8    rows per frame; >=3
//  TIMEOUT     64   done-wait limit in cycles (used only with SOBEL_FEED_TIMEOUT_EN)
// PORTS
//  clka         in   1    clock, all state on rising edge
//  reset        in   1    asynchronous, active-high reset
//  in_pix       in   8    input pixel, raster order
//  in_valid     in   1    in_pix valid
//  in_ready     out  1    feeder accepts; a transfer happens when in_valid&in_ready
//  error_in     in   6    target error; sampled on the first pixel of each frame
//  win_pix      out  168  window; p_k=win_pix[8k+7:8k], k=row*7+col (row 0 = oldest row)
//  win_error    out  6    frame-latched error for the core
//  win_row      out  log2(IMG_HEIGHT)  centre-row index of the current window
//  win_col      out  log2(IMG_WIDTH)   image column of output pixel 0 (=5w+1)
//  start        out  1    1-cycle pulse: window valid, core begins
//  done         in   1    core finished the current window
//  frame_done   out  1    1-cycle pulse after the last window of the frame
//  timeout_err  out  1    sticky flag; exists only with SOBEL_FEED_TIMEOUT_EN
// BEHAVIOUR
//  Reset (async assert, sync release)
//   - Zero after reset: in_ready, win_pix, win_error, win_row, win_col, start, frame_done,
//     timeout_err.
//   - Column, row and window counters reset to 0; line-slot pointer resets to 0.
//   - State is FILL; in_ready goes to 1 in the first cycle after release.
//  States
//   FILL : in_ready=1. Each transfer writes the pixel to slot cur at column col.
//          col wraps at IMG_WIDTH-1, then cur=(cur+1)%3 and row++.
//          On the last column of row r>=2: go to LOAD, in_ready=0 from the next cycle.
//   LOAD : register 21 pixels into win_pix, plus win_row=r-1 and win_col=5w+1.
//          Rows top/mid/bot = slots (cur+1)%3,(cur+2)%3,cur at columns 5w..5w+6.
//          Next state START.
//   START: start=1 for exactly one cycle; next state WAIT.
//   WAIT : win_pix, win_row and win_col are held stable.
//          On done: if w<(IMG_WIDTH-2)/5-1, then w++ and go to LOAD.
//          Otherwise w=0; if r==IMG_HEIGHT-1, pulse frame_done and reset row/cur to 0.
//          In both cases return to FILL.
//  Latency: start is high 2 cycles after the last-column pixel is accepted.
//   After done, the next start follows 2 cycles later.
//  Boundary conditions
//   - done outside WAIT is ignored.
//   - in_valid while in_ready=0 is not consumed; upstream holds it.
//   - Rows 0 and 1 of a frame produce no windows.
//   - Image edge columns 0 and IMG_WIDTH-1 never appear as output pixels.
//   - Reset mid-frame or in WAIT: start drops immediately and the partial frame is discarded.
//   - error_in changes mid-frame have no effect until the next frame.
// CONFIGURATION
//  SOBEL_FEED_TIMEOUT_EN defined
//   - WAIT counts cycles. When the count reaches TIMEOUT with no done, set timeout_err
//     (cleared only by reset) and advance as if done had arrived.
//  SOBEL_FEED_TIMEOUT_EN undefined
//   - WAIT lasts until done, with no limit.
//   - timeout_err port and the counter are absent.
// STRUCTURE
//  sobel_defs.vh, shared with the core and sqrt stages:
//   - PIX_W=8, WIN_ROWS=3, WIN_COLS=7, OUT_PER_WIN=5, ERR_W=6
//   - state encodings FILL/LOAD/START/WAIT
//  Sub-module sobel_line_buffer:
//   - 3xIMG_WIDTH byte store with rotating slot pointer, one write port
//   - combinational 21-pixel window read at a column base
// TESTING
//  1 reset: pulse reset mid-cycle -> all outputs 0 asynchronously; in_ready=1 the cycle
//    after release.
//  2 IMG_WIDTH=12, IMG_HEIGHT=4, pix=row*16+col, done returned 3 cycles after start
//    -> 4 windows total.
//    Window 1: p_0=00, p_6=06, p_7=10, p_14=20, win_row=1, win_col=1.
//    Window 2: p_0=05, p_20=2B, win_col=6.
//    frame_done pulses once after window 4.
//  3 done withheld 50 cycles -> win_pix stable, one start pulse, in_ready=0 throughout.
//  4 in_valid randomly gapped (50%) -> window contents identical to test 2.
//  5 reset asserted in WAIT of row 2 -> start=0 immediately.
//    Next frame's first window arrives only after 3 full rows.
//  6 SOBEL_FEED_TIMEOUT_EN, TIMEOUT=16, done tied 0 -> timeout_err=1 exactly 16 cycles after
//    start; feeder advances to the next window.
//    Without the macro -> stays in WAIT indefinitely.

Source files
------------

// File: rtl/sobel_window_feeder_pkg.sv
// Shared constants, state encoding and slot arithmetic for the Sobel window feeder.
package sobel_window_feeder_pkg;

    localparam int PIX_W       = 8;
    localparam int WIN_ROWS    = 3;
    localparam int WIN_COLS    = 7;
    localparam int OUT_PER_WIN = 5;
    localparam int ERR_W       = 6;
    localparam int WIN_W       = WIN_ROWS * WIN_COLS * PIX_W;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_START = 2'd2,
        ST_WAIT  = 2'd3
    } feed_state_t;

    // Modulo-3 add for the rotating line-slot pointer (s in 0..2, n in 0..3).
    function automatic logic [1:0] slot_add(input logic [1:0] s, input logic [1:0] n);
        logic [2:0] t;
        t = {1'b0, s} + {1'b0, n};
        return (t >= 3'd3) ? 2'(t - 3'd3) : t[1:0];
    endfunction

endpackage

// File: rtl/sobel_window_feeder_line_buffer.sv
// Three-row pixel store with one write port and a combinational 3x7 window read.
// Latency: write visible next cycle, read is combinational; no backpressure of its own.
// Row order on the read side: slot cur+1 (oldest), cur+2, cur (newest).
module sobel_line_buffer
    import sobel_window_feeder_pkg::*;
#(
    parameter int  IMG_WIDTH = 32,
    localparam int CW        = $clog2(IMG_WIDTH)
) (
    input  logic             clka,
    input  logic             wr_en_i,
    input  logic [1:0]       wr_slot_i,
    input  logic [CW-1:0]    wr_col_i,
    input  logic [PIX_W-1:0] wr_pix_i,
    input  logic [1:0]       rd_cur_i,
    input  logic [CW-1:0]    rd_base_i,
    output logic [WIN_W-1:0] win_o
);

    logic [PIX_W-1:0] mem_q [3][IMG_WIDTH];
    logic [1:0]       rd_slot;
    logic [CW-1:0]    rd_col;

    always_ff @(posedge clka) begin
        if (wr_en_i) begin
            mem_q[wr_slot_i][wr_col_i] <= wr_pix_i;
        end
    end

    always_comb begin
        win_o   = '0;
        rd_slot = '0;
        rd_col  = '0;
        for (int r = 0; r < WIN_ROWS; r++) begin
            rd_slot = slot_add(rd_cur_i, 2'(r + 1));
            for (int c = 0; c < WIN_COLS; c++) begin
                rd_col = rd_base_i + CW'(c);
                win_o[(r*WIN_COLS + c)*PIX_W +: PIX_W] = mem_q[rd_slot][rd_col];
            end
        end
    end

endmodule

// File: rtl/sobel_window_feeder.sv
// Raster stream -> 3x7 windows (stride 5) for the Sobel core; optional done-timeout via SOBEL_FEED_TIMEOUT_EN.
// Latency: start 2 cycles after the last pixel of a row (row>=2), and 2 cycles after each done.
// Backpressure: in_ready drops while windows of the current row are in flight to the core.
module sobel_window_feeder
    import sobel_window_feeder_pkg::*;
#(
    parameter int  IMG_WIDTH  = 32,
    parameter int  IMG_HEIGHT = 8,
    parameter int  TIMEOUT    = 64,
    localparam int CW         = $clog2(IMG_WIDTH),
    localparam int RW         = $clog2(IMG_HEIGHT)
) (
    input  logic             clka,
    input  logic             reset,
    input  logic [PIX_W-1:0] in_pix,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ERR_W-1:0] error_in,
    output logic [WIN_W-1:0] win_pix,
    output logic [ERR_W-1:0] win_error,
    output logic [RW-1:0]    win_row,
    output logic [CW-1:0]    win_col,
    output logic             start,
    input  logic             done,
    output logic             frame_done
`ifdef SOBEL_FEED_TIMEOUT_EN
    ,
    output logic             timeout_err
`endif
);

    localparam int NWIN = (IMG_WIDTH - 2) / OUT_PER_WIN;
    localparam int WW   = (NWIN > 1) ? $clog2(NWIN) : 1;

    if ((IMG_WIDTH - 2) % OUT_PER_WIN != 0) begin : g_bad_width
        $error("sobel_window_feeder: (IMG_WIDTH-2) must be a multiple of 5");
    end
    if (IMG_HEIGHT < 3) begin : g_bad_height
        $error("sobel_window_feeder: IMG_HEIGHT must be at least 3");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("sobel_window_feeder: TIMEOUT must be positive");
    end

    feed_state_t      state_q, state_d;
    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic [1:0]       cur_q, cur_d;
    logic [WW-1:0]    w_q, w_d;
    logic             in_ready_q;
    logic             frame_done_q, frame_done_d;
    logic [WIN_W-1:0] win_pix_q;
    logic [ERR_W-1:0] err_q;
    logic [RW-1:0]    win_row_q;
    logic [CW-1:0]    win_col_q;
    logic [WIN_W-1:0] rd_win;
    logic [CW-1:0]    base_col;
    logic             xfer, tmo_hit, adv;

    assign xfer     = in_valid & in_ready_q;
    assign base_col = CW'(w_q) * CW'(OUT_PER_WIN);
    assign adv      = (state_q == ST_WAIT) && (done || tmo_hit);

    sobel_line_buffer #(.IMG_WIDTH(IMG_WIDTH)) u_lbuf (
        .clka      (clka),
        .wr_en_i   (xfer),
        .wr_slot_i (cur_q),
        .wr_col_i  (col_q),
        .wr_pix_i  (in_pix),
        .rd_cur_i  (cur_q),
        .rd_base_i (base_col),
        .win_o     (rd_win)
    );

`ifdef SOBEL_FEED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q;
    logic          tmo_err_q;

    // Count runs from the start cycle, so the flag lands TIMEOUT cycles after start.
    assign tmo_hit     = (state_q == ST_WAIT) && !done && (tmo_q == TW'(TIMEOUT - 1));
    assign timeout_err = tmo_err_q;

    always_ff @(posedge clka or posedge reset) begin
        if (reset) begin
            tmo_q     <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_q <= (state_q == ST_START || state_q == ST_WAIT) ? tmo_q + TW'(1) : '0;
            if (tmo_hit) begin
                tmo_err_q <= 1'b1;
            end
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // Row/slot only advance after the row's windows are issued, so LOAD still sees cur as newest.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        cur_d        = cur_q;
        w_d          = w_q;
        frame_done_d = 1'b0;
        unique case (state_q)
            ST_FILL: begin
                if (xfer) begin
                    if (col_q == CW'(IMG_WIDTH - 1)) begin
                        col_d = '0;
                        if (row_q >= RW'(2)) begin
                            state_d = ST_LOAD;
                        end else begin
                            row_d = row_q + RW'(1);
                            cur_d = slot_add(cur_q, 2'd1);
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            ST_LOAD:  state_d = ST_START;
            ST_START: state_d = ST_WAIT;
            ST_WAIT: begin
                if (adv) begin
                    if (w_q < WW'(NWIN - 1)) begin
                        w_d     = w_q + WW'(1);
                        state_d = ST_LOAD;
                    end else begin
                        w_d     = '0;
                        state_d = ST_FILL;
                        if (row_q == RW'(IMG_HEIGHT - 1)) begin
                            row_d        = '0;
                            cur_d        = '0;
                            frame_done_d = 1'b1;
                        end else begin
                            row_d = row_q + RW'(1);
                            cur_d = slot_add(cur_q, 2'd1);
                        end
                    end
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    always_ff @(posedge clka or posedge reset) begin
        if (reset) begin
            state_q      <= ST_FILL;
            col_q        <= '0;
            row_q        <= '0;
            cur_q        <= '0;
            w_q          <= '0;
            in_ready_q   <= 1'b0;
            frame_done_q <= 1'b0;
            win_pix_q    <= '0;
            err_q        <= '0;
            win_row_q    <= '0;
            win_col_q    <= '0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            cur_q        <= cur_d;
            w_q          <= w_d;
            in_ready_q   <= (state_d == ST_FILL);
            frame_done_q <= frame_done_d;
            if (xfer && row_q == '0 && col_q == '0) begin
                err_q <= error_in;
            end
            if (state_q == ST_LOAD) begin
                win_pix_q <= rd_win;
                win_row_q <= row_q - RW'(1);
                win_col_q <= base_col + CW'(1);
            end
        end
    end

    assign in_ready   = in_ready_q;
    assign start      = (state_q == ST_START);
    assign frame_done = frame_done_q;
    assign win_pix    = win_pix_q;
    assign win_error  = err_q;
    assign win_row    = win_row_q;
    assign win_col    = win_col_q;

endmodule
